mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the two cache requesters, memory and the arbiter.
// master = environment side (caches + memory), slave = the arbiter.
interface mem_arbiter_if;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_req_accepted;
  logic        dc_req_valid;
  logic [1:0]  dc_req_cmd;
  logic [31:0] dc_req_addr;
  logic [63:0] dc_req_data;
  logic        dc_req_accepted;
  logic [1:0]  mem_cmd;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [3:0]  mem_resp_tag;
  logic [3:0]  req_tag;
  logic [63:0] mem_data;
  logic [3:0]  mem_data_tag;
  logic        ic_data_valid;
  logic        dc_data_valid;
  logic [63:0] data_out;
  logic [3:0]  data_tag;
  logic [3:0]  outstanding;
  logic        tag_error;

  modport master (
    output ic_req_valid, ic_req_addr, dc_req_valid, dc_req_cmd, dc_req_addr, dc_req_data,
           mem_resp_tag, mem_data, mem_data_tag,
    input  ic_req_accepted, dc_req_accepted, mem_cmd, mem_addr, mem_wdata, req_tag,
           ic_data_valid, dc_data_valid, data_out, data_tag, outstanding, tag_error
  );

  modport slave (
    input  ic_req_valid, ic_req_addr, dc_req_valid, dc_req_cmd, dc_req_addr, dc_req_data,
           mem_resp_tag, mem_data, mem_data_tag,
    output ic_req_accepted, dc_req_accepted, mem_cmd, mem_addr, mem_wdata, req_tag,
           ic_data_valid, dc_data_valid, data_out, data_tag, outstanding, tag_error
  );
endinterface

// File: rtl/mem_arbiter.sv
// Icache/dcache memory arbiter with starvation guard and per-tag load ownership table.
// Grant, accept and return routing are same-cycle; retries on mem_resp_tag == 0 need no arbiter state.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_MEM_TAGS = 15
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [2:0] LIMIT     = 3'(STARVE_LIMIT);

  // Entries above NUM_MEM_TAGS and entry 0 are never set, so any tag value indexes safely.
  function automatic logic [15:0] tag_mask_f();
    logic [15:0] m;
    m = '0;
    for (int t = 1; t <= NUM_MEM_TAGS && t < 16; t++) m[t] = 1'b1;
    return m;
  endfunction
  localparam logic [15:0] TAG_MASK = tag_mask_f();

  logic [15:0] r_valid, r_owner;
  logic [2:0]  r_starve_cnt;
  logic [3:0]  r_outstanding;
  logic        r_tag_error;

  logic [15:0] w_valid, w_owner, w_valid_nxt, w_owner_nxt;
  logic [2:0]  w_starve_cnt, w_starve_nxt;
  logic        w_ic_prio, w_gnt_ic, w_gnt_dc, w_tag_ok;
  logic        w_ic_acc, w_dc_acc, w_load_acc, w_load_ok;
  logic        w_ret_nz, w_ret_hit, w_same_tag, w_err_set;

  // While reset is held, combinational outputs already see the cleared state.
  assign w_valid      = reset ? '0 : r_valid;
  assign w_owner      = reset ? '0 : r_owner;
  assign w_starve_cnt = reset ? '0 : r_starve_cnt;

  assign w_ic_prio = bus.ic_req_valid && (w_starve_cnt == LIMIT);
  assign w_gnt_dc  = bus.dc_req_valid && !w_ic_prio;
  assign w_gnt_ic  = bus.ic_req_valid && !w_gnt_dc;
  assign w_tag_ok  = (bus.mem_resp_tag != 4'd0);
  assign w_ic_acc  = w_gnt_ic && w_tag_ok;
  assign w_dc_acc  = w_gnt_dc && w_tag_ok;

  assign bus.ic_req_accepted = w_ic_acc;
  assign bus.dc_req_accepted = w_dc_acc;
  assign bus.req_tag         = bus.mem_resp_tag;
  assign bus.data_out        = bus.mem_data;
  assign bus.data_tag        = bus.mem_data_tag;

  always_comb begin
    bus.mem_cmd   = CMD_NONE;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (w_gnt_dc) begin
      bus.mem_cmd   = bus.dc_req_cmd;
      bus.mem_addr  = bus.dc_req_addr;
      bus.mem_wdata = bus.dc_req_data;
    end else if (w_gnt_ic) begin
      bus.mem_cmd   = CMD_LOAD;
      bus.mem_addr  = bus.ic_req_addr;
    end
  end

  assign w_load_acc = w_ic_acc || (w_dc_acc && bus.dc_req_cmd == CMD_LOAD);
  assign w_load_ok  = TAG_MASK[bus.mem_resp_tag];
  assign w_ret_nz   = (bus.mem_data_tag != 4'd0);
  assign w_ret_hit  = w_ret_nz && w_valid[bus.mem_data_tag];
  assign w_same_tag = w_ret_hit && (bus.mem_data_tag == bus.mem_resp_tag);

  assign bus.ic_data_valid = w_ret_hit && !w_owner[bus.mem_data_tag];
  assign bus.dc_data_valid = w_ret_hit &&  w_owner[bus.mem_data_tag];

  // Clear on return first, then a same-cycle accept on the same tag re-sets it.
  always_comb begin
    w_valid_nxt = w_valid;
    w_owner_nxt = w_owner;
    if (w_ret_hit) w_valid_nxt[bus.mem_data_tag] = 1'b0;
    if (w_load_acc && w_load_ok) begin
      w_valid_nxt[bus.mem_resp_tag] = 1'b1;
      w_owner_nxt[bus.mem_resp_tag] = w_gnt_dc;
    end
  end

  assign w_err_set = (w_ret_nz && !w_ret_hit)
                   || (w_load_acc && !w_load_ok)
                   || (w_load_acc && w_load_ok && w_valid[bus.mem_resp_tag] && !w_same_tag);

  always_comb begin
    w_starve_nxt = w_starve_cnt;
    if (!bus.ic_req_valid || w_ic_acc) w_starve_nxt = 3'd0;
    else if (w_starve_cnt != LIMIT)    w_starve_nxt = w_starve_cnt + 3'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid       <= '0;
      r_owner       <= '0;
      r_starve_cnt  <= '0;
      r_outstanding <= '0;
      r_tag_error   <= 1'b0;
    end else begin
      r_valid       <= w_valid_nxt;
      r_owner       <= w_owner_nxt;
      r_starve_cnt  <= w_starve_nxt;
      r_outstanding <= 4'($countones(w_valid_nxt));
      r_tag_error   <= r_tag_error || w_err_set;
    end
  end

  assign bus.outstanding = reset ? 4'd0 : r_outstanding;
  assign bus.tag_error   = reset ? 1'b0 : r_tag_error;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run against a tag-ownership model.
module tb_mem_arbiter;
  localparam int LIMIT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if bus();
  mem_arbiter #(.STARVE_LIMIT(LIMIT), .NUM_MEM_TAGS(15)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  // Model: owner of each tag (0 = free, 1 = icache, 2 = dcache), consecutive icache waits, sticky error.
  int m_tab[16];
  int m_wait;
  bit m_err;
  int n_tab[16];
  int n_wait;
  bit n_err;

  bit          e_ic_acc, e_dc_acc, e_icdv, e_dcdv, e_err;
  logic [1:0]  e_cmd;
  logic [31:0] e_addr;
  logic [63:0] e_wdata;
  int          e_out;

  task automatic model_eval();
    int gnt, rt, dt;
    bit hit;
    if (reset) begin
      foreach (m_tab[i]) m_tab[i] = 0;
      m_wait = 0;
      m_err  = 0;
    end
    rt = int'(bus.mem_resp_tag);
    dt = int'(bus.mem_data_tag);
    if (m_wait >= LIMIT && bus.ic_req_valid)  gnt = 1;
    else if (bus.dc_req_valid)                gnt = 2;
    else if (bus.ic_req_valid)                gnt = 1;
    else                                      gnt = 0;
    e_cmd   = (gnt == 2) ? bus.dc_req_cmd : (gnt == 1) ? 2'd1 : 2'd0;
    e_addr  = (gnt == 2) ? bus.dc_req_addr : (gnt == 1) ? bus.ic_req_addr : 32'd0;
    e_wdata = (gnt == 2) ? bus.dc_req_data : 64'd0;
    e_ic_acc = (gnt == 1) && rt != 0;
    e_dc_acc = (gnt == 2) && rt != 0;
    e_out = 0;
    foreach (m_tab[i]) if (m_tab[i] != 0) e_out++;
    e_err = m_err;
    n_tab = m_tab;
    n_err = m_err;
    hit   = (dt != 0) && (m_tab[dt] != 0);
    e_icdv = hit && m_tab[dt] == 1;
    e_dcdv = hit && m_tab[dt] == 2;
    if (dt != 0 && !hit) n_err = 1;
    if (hit) n_tab[dt] = 0;
    if ((e_ic_acc || (e_dc_acc && bus.dc_req_cmd == 2'd1))) begin
      if (m_tab[rt] != 0 && !(hit && dt == rt)) n_err = 1;
      n_tab[rt] = gnt;
    end
    n_wait = (bus.ic_req_valid && !e_ic_acc) ? ((m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1) : 0;
    if (reset) begin
      foreach (n_tab[i]) n_tab[i] = 0;
      n_wait = 0;
      n_err  = 0;
    end
  endtask

  task automatic apply(input bit icv, input logic [31:0] ica, input bit dcv, input logic [1:0] dcc,
                       input logic [31:0] dca, input logic [63:0] dcd, input logic [3:0] rt,
                       input logic [3:0] dt, input logic [63:0] md);
    bus.ic_req_valid = icv;  bus.ic_req_addr = ica;
    bus.dc_req_valid = dcv;  bus.dc_req_cmd  = dcc;
    bus.dc_req_addr  = dca;  bus.dc_req_data = dcd;
    bus.mem_resp_tag = rt;   bus.mem_data_tag = dt;  bus.mem_data = md;
    model_eval();
    #2;
  endtask

  task automatic tick();
    @(posedge clock);
    m_tab = n_tab;
    m_wait = n_wait;
    m_err = n_err;
    #1;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 4'd6, 0, 64'h1234_5678_9abc_def0);
    checks++; if (bus.outstanding !== 4'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", bus.outstanding); end
    checks++; if (bus.tag_error !== 1'b0) begin errors++; $display("FAIL reset_tag_error: got %b want 0", bus.tag_error); end
    checks++; if (bus.mem_cmd !== 2'd0 || bus.mem_addr !== 32'd0) begin errors++; $display("FAIL reset_cmd: got cmd %0d addr %h want 0/0", bus.mem_cmd, bus.mem_addr); end
    checks++; if (bus.req_tag !== 4'd6 || bus.data_out !== 64'h1234_5678_9abc_def0) begin errors++; $display("FAIL reset_passthru: got tag %0d data %h", bus.req_tag, bus.data_out); end
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_ic_load();
    apply(1, 32'h100, 0, 0, 0, 0, 4'd3, 0, 0);
    checks++; if (bus.ic_req_accepted !== 1'b1 || bus.dc_req_accepted !== 1'b0) begin errors++; $display("FAIL ic_load_acc: got ic %b dc %b want 1/0", bus.ic_req_accepted, bus.dc_req_accepted); end
    checks++; if (bus.req_tag !== 4'd3 || bus.mem_cmd !== 2'd1 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 64'd0) begin errors++; $display("FAIL ic_load_cmd: got tag %0d cmd %0d addr %h wdata %h", bus.req_tag, bus.mem_cmd, bus.mem_addr, bus.mem_wdata); end
    tick();
    idle();
    checks++; if (bus.outstanding !== 4'd1) begin errors++; $display("FAIL ic_load_outstanding: got %0d want 1", bus.outstanding); end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 4'd3, 64'hCAFE_F00D_0000_0001);
    checks++; if (bus.ic_data_valid !== 1'b1 || bus.dc_data_valid !== 1'b0) begin errors++; $display("FAIL ic_load_return: got icdv %b dcdv %b want 1/0", bus.ic_data_valid, bus.dc_data_valid); end
    checks++; if (bus.data_out !== 64'hCAFE_F00D_0000_0001 || bus.data_tag !== 4'd3) begin errors++; $display("FAIL ic_load_data: got %h tag %0d", bus.data_out, bus.data_tag); end
    tick();
    idle();
    checks++; if (bus.outstanding !== 4'd0 || bus.tag_error !== 1'b0) begin errors++; $display("FAIL ic_load_drain: got out %0d err %b want 0/0", bus.outstanding, bus.tag_error); end
    tick();
  endtask

  task automatic test_starvation();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply(1, 32'h40 + 32'(i), 1, 2'd2, 32'h80, 64'd0, 4'(i + 1), 0, 0);
      checks++;
      if (bus.ic_req_accepted !== (i % 5 == 4) || bus.dc_req_accepted !== (i % 5 != 4)) begin
        errors++; $display("FAIL starve_cycle%0d: got ic %b dc %b want ic %b", i, bus.ic_req_accepted, bus.dc_req_accepted, (i % 5 == 4));
      end
      tick();
    end
  endtask

  task automatic test_store();
    do_reset();
    apply(0, 0, 1, 2'd2, 32'h200, 64'hDEADBEEF, 4'd5, 0, 0);
    checks++; if (bus.mem_cmd !== 2'd2 || bus.dc_req_accepted !== 1'b1 || bus.ic_req_accepted !== 1'b0) begin errors++; $display("FAIL store_acc: got cmd %0d dc %b ic %b", bus.mem_cmd, bus.dc_req_accepted, bus.ic_req_accepted); end
    checks++; if (bus.mem_addr !== 32'h200 || bus.mem_wdata !== 64'hDEADBEEF) begin errors++; $display("FAIL store_bus: got addr %h wdata %h", bus.mem_addr, bus.mem_wdata); end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 4'd5, 0);
    checks++; if (bus.outstanding !== 4'd0 || bus.dc_data_valid !== 1'b0 || bus.ic_data_valid !== 1'b0) begin errors++; $display("FAIL store_no_entry: got out %0d dcdv %b icdv %b", bus.outstanding, bus.dc_data_valid, bus.ic_data_valid); end
    tick();
  endtask

  task automatic test_same_cycle();
    do_reset();
    apply(1, 32'h300, 0, 0, 0, 0, 4'd7, 0, 0);
    tick();
    apply(0, 0, 1, 2'd1, 32'h340, 0, 4'd7, 4'd7, 64'h77);
    checks++; if (bus.ic_data_valid !== 1'b1 || bus.dc_req_accepted !== 1'b1) begin errors++; $display("FAIL same_cycle_route: got icdv %b dcacc %b want 1/1", bus.ic_data_valid, bus.dc_req_accepted); end
    tick();
    idle();
    checks++; if (bus.outstanding !== 4'd1 || bus.tag_error !== 1'b0) begin errors++; $display("FAIL same_cycle_state: got out %0d err %b want 1/0", bus.outstanding, bus.tag_error); end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 4'd7, 64'h78);
    checks++; if (bus.dc_data_valid !== 1'b1 || bus.ic_data_valid !== 1'b0) begin errors++; $display("FAIL same_cycle_owner: got dcdv %b icdv %b want 1/0", bus.dc_data_valid, bus.ic_data_valid); end
    tick();
  endtask

  task automatic test_orphan();
    do_reset();
    apply(0, 0, 0, 0, 0, 0, 0, 4'd9, 64'h99);
    checks++; if (bus.ic_data_valid !== 1'b0 || bus.dc_data_valid !== 1'b0) begin errors++; $display("FAIL orphan_dv: got icdv %b dcdv %b want 0/0", bus.ic_data_valid, bus.dc_data_valid); end
    tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++; if (bus.tag_error !== 1'b1) begin errors++; $display("FAIL orphan_sticky%0d: got %b want 1", i, bus.tag_error); end
      tick();
    end
    do_reset();
    idle();
    checks++; if (bus.tag_error !== 1'b0) begin errors++; $display("FAIL orphan_cleared: got %b want 0", bus.tag_error); end
  endtask

  task automatic test_no_accept();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1, 32'h500, 0, 0, 0, 0, 4'd0, 0, 0);
      checks++; if (bus.ic_req_accepted !== 1'b0 || bus.mem_cmd !== 2'd1) begin errors++; $display("FAIL noacc_cycle%0d: got acc %b cmd %0d want 0/1", i, bus.ic_req_accepted, bus.mem_cmd); end
      tick();
    end
    apply(1, 32'h500, 1, 2'd2, 32'h600, 64'h1, 4'd2, 0, 0);
    checks++; if (bus.dc_req_accepted !== 1'b1 || bus.ic_req_accepted !== 1'b0 || bus.outstanding !== 4'd0) begin errors++; $display("FAIL noacc_wait3: got dc %b ic %b out %0d want 1/0/0", bus.dc_req_accepted, bus.ic_req_accepted, bus.outstanding); end
    tick();
    apply(1, 32'h500, 1, 2'd2, 32'h600, 64'h1, 4'd2, 0, 0);
    checks++; if (bus.ic_req_accepted !== 1'b1 || bus.dc_req_accepted !== 1'b0) begin errors++; $display("FAIL noacc_wait4: got ic %b dc %b want 1/0", bus.ic_req_accepted, bus.dc_req_accepted); end
    tick();
  endtask

  task automatic test_midflight_reset();
    do_reset();
    apply(1, 32'h700, 0, 0, 0, 0, 4'd4, 0, 0);
    tick();
    apply(0, 0, 1, 2'd1, 32'h780, 0, 4'd6, 0, 0);
    tick();
    reset = 1'b1;
    idle();
    checks++; if (bus.outstanding !== 4'd0) begin errors++; $display("FAIL midreset_out: got %0d want 0", bus.outstanding); end
    tick();
    reset = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 0, 4'd4, 64'h4);
    checks++; if (bus.ic_data_valid !== 1'b0 || bus.dc_data_valid !== 1'b0) begin errors++; $display("FAIL midreset_stale: got icdv %b dcdv %b want 0/0", bus.ic_data_valid, bus.dc_data_valid); end
    tick();
    idle();
    checks++; if (bus.tag_error !== 1'b1) begin errors++; $display("FAIL midreset_err: got %b want 1", bus.tag_error); end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] rt, dt;
    int live[$];
    do_reset();
    for (int c = 0; c < 600; c++) begin
      live.delete();
      for (int t = 1; t < 16; t++) if (m_tab[t] != 0) live.push_back(t);
      rt = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
      if (live.size() > 0 && $urandom_range(1) == 1) dt = 4'(live[$urandom_range(live.size() - 1)]);
      else dt = ($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'd0;
      reset = ($urandom_range(80) == 0);
      apply($urandom_range(1) == 1, $urandom, $urandom_range(1) == 1, 2'($urandom_range(2, 1)),
            $urandom, {$urandom, $urandom}, rt, dt, {$urandom, $urandom});
      checks++;
      if (bus.ic_req_accepted !== e_ic_acc || bus.dc_req_accepted !== e_dc_acc || bus.mem_cmd !== e_cmd ||
          bus.mem_addr !== e_addr || bus.mem_wdata !== e_wdata || bus.req_tag !== rt) begin
        errors++; $display("FAIL rand_req c%0d: got acc %b%b cmd %0d addr %h tag %0d want acc %b%b cmd %0d addr %h tag %0d",
                           c, bus.ic_req_accepted, bus.dc_req_accepted, bus.mem_cmd, bus.mem_addr, bus.req_tag,
                           e_ic_acc, e_dc_acc, e_cmd, e_addr, rt);
      end
      checks++;
      if (bus.ic_data_valid !== e_icdv || bus.dc_data_valid !== e_dcdv || bus.outstanding !== 4'(e_out) ||
          bus.tag_error !== e_err || bus.data_tag !== dt) begin
        errors++; $display("FAIL rand_ret c%0d: got dv %b%b out %0d err %b want dv %b%b out %0d err %b",
                           c, bus.ic_data_valid, bus.dc_data_valid, bus.outstanding, bus.tag_error,
                           e_icdv, e_dcdv, e_out, e_err);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    foreach (m_tab[i]) m_tab[i] = 0;
    m_wait = 0;
    m_err  = 0;
    test_reset();
    test_ic_load();
    test_starvation();
    test_store();
    test_same_cycle();
    test_orphan();
    test_no_accept();
    test_midflight_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
